// File: rtl/control_pipeline_register.sv
// -----------------------------------------------------------------------------
// control_pipeline_register
//
// Multi-stage pipeline register for the microprogrammed control unit. It sits
// between the microstore output and the field-decode logic that drives the
// register load enables (fr_ld, rf_ld, ir_ld, mar_ld, ...). Each of the STAGES
// stages carries a microinstruction word, the microstore state number that
// produced it, and a valid bit.
//
// Per rising clock edge (reset low), the priority is flush > stall > shift:
//   flush : every stage becomes a NOP bubble. The same-cycle input is dropped.
//           The stall counter and the timeout flag are cleared.
//   stall : every stage holds. The input is not captured, so upstream must
//           hold it. The stall counter counts up and saturates at STALL_MAX+1.
//   shift : stage 0 takes the input, or a bubble when in_valid is low.
//           Stage k takes stage k-1. The stall counter is cleared.
// stall_timeout sets when the stall counter reaches STALL_MAX+1. It is sticky
// until a flush or a reset.
//
// Reset is asynchronous and active-high. The outputs clear as soon as reset
// asserts, without waiting for a clock edge.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   in            in   [WORD_W]   microinstruction from the microstore
//   in_state      in   [STATE_W]  state number that produced `in`
//   in_valid      in   in / in_state are meaningful this cycle
//   stall         in   hold all stages
//   flush         in   invalidate all stages
//   out           out  [WORD_W]   final-stage microinstruction (registered)
//   out_state     out  [STATE_W]  final-stage state number (registered)
//   out_valid     out  final stage holds a valid word (registered)
//   occupancy     out  [$clog2(STAGES+1)]  number of valid stages (registered)
//   stall_timeout out  sticky stall watchdog flag
// -----------------------------------------------------------------------------
module control_pipeline_register #(
  parameter int                WORD_W    = 34,
  parameter int                STATE_W   = 10,
  parameter int                STAGES    = 2,
  parameter logic [WORD_W-1:0] NOP_WORD  = '0,
  parameter int                STALL_MAX = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_W-1:0]            in,
  input  logic [STATE_W-1:0]           in_state,
  input  logic                         in_valid,
  input  logic                         stall,
  input  logic                         flush,
  output logic [WORD_W-1:0]            out,
  output logic [STATE_W-1:0]           out_state,
  output logic                         out_valid,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic                         stall_timeout
);

  localparam int OCC_W = $clog2(STAGES + 1);
  // The counter must be able to hold STALL_MAX+1, which is its saturation value.
  localparam int CNT_W = $clog2(STALL_MAX + 2);
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(STALL_MAX + 1);

  // Next-cycle valid bits of all stages. Occupancy is registered from these,
  // so it always matches the stage valids that the same edge latches.
  logic [STAGES-1:0] valid_next_vec;

  // ---------------------------------------------------------------------------
  // Stage datapath
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WORD_W-1:0]  word_q,  word_d,  src_word;
    logic [STATE_W-1:0] state_q, state_d, src_state;
    logic               valid_q, valid_d, src_valid;

    if (gi == 0) begin : g_head
      // A cycle without a valid input shifts in a bubble. The bubble uses the
      // NOP word with all load enables off, so stray input bits never reach
      // the field decode.
      assign src_word  = in_valid ? in       : NOP_WORD;
      assign src_state = in_valid ? in_state : '0;
      assign src_valid = in_valid;
    end else begin : g_body
      assign src_word  = g_stage[gi-1].word_q;
      assign src_state = g_stage[gi-1].state_q;
      assign src_valid = g_stage[gi-1].valid_q;
    end

    always_comb begin
      word_d  = word_q;
      state_d = state_q;
      valid_d = valid_q;
      if (flush) begin
        word_d  = NOP_WORD;
        state_d = '0;
        valid_d = 1'b0;
      end else if (!stall) begin
        word_d  = src_word;
        state_d = src_state;
        valid_d = src_valid;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_q  <= NOP_WORD;
        state_q <= '0;
        valid_q <= 1'b0;
      end else begin
        word_q  <= word_d;
        state_q <= state_d;
        valid_q <= valid_d;
      end
    end

    assign valid_next_vec[gi] = valid_d;
  end

  // ---------------------------------------------------------------------------
  // Occupancy: population count of the next-cycle valid bits
  // ---------------------------------------------------------------------------
  logic [OCC_W-1:0] occupancy_q, occupancy_d;

  always_comb begin
    occupancy_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy_d = occupancy_d + OCC_W'(valid_next_vec[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy_q <= '0;
    end else begin
      occupancy_q <= occupancy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_timeout_q, stall_timeout_d;

  always_comb begin
    stall_cnt_d     = stall_cnt_q;
    stall_timeout_d = stall_timeout_q;
    if (flush) begin
      stall_cnt_d     = '0;
      stall_timeout_d = 1'b0;
    end else if (stall) begin
      // A stall counts even when the pipe is empty. The counter saturates so
      // that a long stall cannot wrap it back below the limit.
      if (stall_cnt_q != STALL_LIMIT) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (stall_cnt_d == STALL_LIMIT) begin
        stall_timeout_d = 1'b1;
      end
    end else begin
      // A shift edge restarts the count. The sticky flag is left alone.
      stall_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q     <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: taken straight from flops, with no combinational path from inputs
  // ---------------------------------------------------------------------------
  assign out           = g_stage[STAGES-1].word_q;
  assign out_state     = g_stage[STAGES-1].state_q;
  assign out_valid     = g_stage[STAGES-1].valid_q;
  assign occupancy     = occupancy_q;
  assign stall_timeout = stall_timeout_q;

endmodule

// File: tb/tb_control_pipeline_register.sv
// -----------------------------------------------------------------------------
// tb_control_pipeline_register
//
// Directed-vector bench for control_pipeline_register. Three instances share
// the clock and all inputs:
//   dut2  STAGES=2  main functional checks
//   dut1  STAGES=1  latency of one edge
//   dut8  STAGES=8  latency of eight edges and occupancy saturation
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_control_pipeline_register;

  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] in_w;
  logic [9:0]  in_state;
  logic        in_valid;
  logic        stall;
  logic        flush;

  logic [33:0] out2, out1, out8;
  logic [9:0]  out_state2, out_state1, out_state8;
  logic        out_valid2, out_valid1, out_valid8;
  logic [1:0]  occ2;
  logic [0:0]  occ1;
  logic [3:0]  occ8;
  logic        tmo2, tmo1, tmo8;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  control_pipeline_register #(.STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .in(in_w), .in_state(in_state), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out2), .out_state(out_state2),
    .out_valid(out_valid2), .occupancy(occ2), .stall_timeout(tmo2)
  );

  control_pipeline_register #(.STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in(in_w), .in_state(in_state), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out1), .out_state(out_state1),
    .out_valid(out_valid1), .occupancy(occ1), .stall_timeout(tmo1)
  );

  control_pipeline_register #(.STAGES(8)) dut8 (
    .clk(clk), .reset(reset), .in(in_w), .in_state(in_state), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out(out8), .out_state(out_state8),
    .out_valid(out_valid8), .occupancy(occ8), .stall_timeout(tmo8)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [33:0] w, input logic [9:0] s, input logic v);
    in_w     = w;
    in_state = s;
    in_valid = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(34'h0, 10'd0, 1'b0);
    stall = 1'b0;
    flush = 1'b0;
    step();
    step();
    reset = 1'b0;

    // --- reset state ----------------------------------------------------------
    check_val("rst_out", out2, 0);
    check_val("rst_valid", out_valid2, 0);
    check_val("rst_occ", occ2, 0);
    check_val("rst_tmo", tmo2, 0);

    // --- asynchronous reset between edges --------------------------------------
    drive(34'h1234, 10'd4, 1'b1);
    step();
    step();
    check_val("pre_async_valid", out_valid2, 1);
    #3 reset = 1'b1;
    #1;
    check_val("async_out", out2, 0);
    check_val("async_valid", out_valid2, 0);
    check_val("async_occ", occ2, 0);
    check_val("async_tmo", tmo2, 0);
    step();
    reset = 1'b0;
    drive(34'h0, 10'd0, 1'b0);

    // --- streaming: occupancy 1,2,1,0 ---------------------------------------
    drive(34'h1234, 10'd4, 1'b1);
    step();
    check_val("strm_occ1", occ2, 1);
    check_val("strm_valid1", out_valid2, 0);
    drive(34'h2_0000, 10'd20, 1'b1);
    step();
    check_val("strm_out_a", out2, 34'h1234);
    check_val("strm_state_a", out_state2, 4);
    check_val("strm_valid_a", out_valid2, 1);
    check_val("strm_occ2", occ2, 2);
    drive(34'h0, 10'd0, 1'b0);
    step();
    check_val("strm_out_b", out2, 34'h2_0000);
    check_val("strm_state_b", out_state2, 20);
    check_val("strm_occ3", occ2, 1);
    step();
    check_val("strm_valid_end", out_valid2, 0);
    check_val("strm_out_end", out2, 0);
    check_val("strm_occ4", occ2, 0);

    // --- stall hold -----------------------------------------------------------
    drive(34'h1234, 10'd1, 1'b1);
    step();
    drive(34'h5678, 10'd2, 1'b1);
    step();
    check_val("hold_pre_out", out2, 34'h1234);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(34'h1111 + 34'(i), 10'd7, 1'b1);
      step();
      check_val("hold_out", out2, 34'h1234);
      check_val("hold_occ", occ2, 2);
    end
    stall = 1'b0;
    drive(34'h9ABC, 10'd9, 1'b1);
    step();
    check_val("hold_rel_out", out2, 34'h5678);
    check_val("hold_rel_state", out_state2, 2);
    drive(34'h0, 10'd0, 1'b0);
    step();
    check_val("hold_new_out", out2, 34'h9ABC);
    check_val("hold_new_state", out_state2, 9);
    check_val("hold_new_occ", occ2, 1);
    step();

    // --- flush beats stall; same-cycle input is discarded --------------------
    drive(34'h1111, 10'd3, 1'b1);
    step();
    drive(34'h2222, 10'd5, 1'b1);
    step();
    check_val("fl_pre_occ", occ2, 2);
    flush = 1'b1;
    stall = 1'b1;
    drive(34'hABC, 10'd6, 1'b1);
    step();
    check_val("fl_out", out2, 0);
    check_val("fl_state", out_state2, 0);
    check_val("fl_valid", out_valid2, 0);
    check_val("fl_occ", occ2, 0);
    flush = 1'b0;
    stall = 1'b0;
    drive(34'h0, 10'd0, 1'b0);
    step();
    check_val("fl_after_valid", out_valid2, 0);
    check_val("fl_after_out", out2, 0);

    // --- a shift edge clears the stall counter ----------------------------------
    stall = 1'b1;
    for (int i = 0; i < 10; i++) step();
    stall = 1'b0;
    step();
    stall = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_val("cnt_clear_tmo", tmo2, 0);
    stall = 1'b0;
    step();

    // --- watchdog: 15 stalls ok, 16th trips it ---------------------------------
    stall = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check_val("wd_15", tmo2, 0);
    step();
    check_val("wd_16", tmo2, 1);
    step();
    step();
    check_val("wd_sat", tmo2, 1);
    stall = 1'b0;
    step();
    check_val("wd_sticky", tmo2, 1);
    drive(34'h77, 10'd1, 1'b1);
    step();
    check_val("wd_sticky_shift", tmo2, 1);
    drive(34'h0, 10'd0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_val("wd_flush_clr", tmo2, 0);

    // --- depth sweep: latency 1 edge (STAGES=1) and 8 edges (STAGES=8) ------
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(34'h3_0001, 10'd11, 1'b1);
    step();
    drive(34'h0, 10'd0, 1'b0);
    check_val("d1_out", out1, 34'h3_0001);
    check_val("d1_state", out_state1, 11);
    check_val("d1_valid", out_valid1, 1);
    check_val("d8_valid_e1", out_valid8, 0);
    for (int k = 2; k <= 8; k++) begin
      step();
      check_val("d1_valid_later", out_valid1, 0);
      check_val("d8_valid", out_valid8, (k == 8) ? 1 : 0);
      check_val("d8_occ_single", occ8, 1);
    end
    check_val("d8_out", out8, 34'h3_0001);
    check_val("d8_state", out_state8, 11);

    // --- occupancy saturates at 8 without wrapping -------------------------------
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(34'(k), 10'(k), 1'b1);
      step();
      check_val("d8_occ", occ8, (k < 8) ? k : 8);
      check_val("d1_occ", occ1, 1);
      if (k >= 8) check_val("d8_stream_out", out8, k - 7);
    end
    drive(34'h0, 10'd0, 1'b0);

    // --- asynchronous reset while stalled with the watchdog tripped ---------
    stall = 1'b1;
    for (int i = 0; i < 16; i++) step();
    check_val("mid_stall_tmo", tmo2, 1);
    check_val("mid_stall_occ8", occ8, 8);
    #3 reset = 1'b1;
    #1;
    check_val("mid_rst_tmo", tmo2, 0);
    check_val("mid_rst_valid", out_valid2, 0);
    check_val("mid_rst_occ2", occ2, 0);
    check_val("mid_rst_occ8", occ8, 0);
    check_val("mid_rst_out8", out8, 0);
    step();
    reset = 1'b0;
    stall = 1'b0;
    step();
    check_val("post_rst_tmo", tmo2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
